// File: rtl/me_sad_search.sv
// me_sad_search: pipelined SAD reduction and multi-batch best-match search.
// Three stages: per-lane row sums, per-batch minimum, running block minimum.
//
// Ports:
//   clk, rst            clock and synchronous active-low reset
//   psad_valid_i/o      beat handshake (psad_ready_o) for psad_i
//   psad_i              EDGE_LEN x CAND_PER_BATCH row partial SADs
//   flush_i             abort current block, drop in-flight beats
//   best_valid_o/i      result handshake (best_ready_i)
//   best_sad_o          minimum SAD of the block
//   best_idx_o          batch*CAND_PER_BATCH + lane of that minimum
//
// Optional feature macro ME_EARLY_TERM_EN adds:
//   term_thresh_i       early-termination threshold
//   best_early_o        result was emitted before the last batch
module me_sad_search #(
    parameter int CAND_PER_BATCH = 16,
    parameter int EDGE_LEN       = 8,
    parameter int PSAD_BIT_WIDTH = 11,
    parameter int SAD_BIT_WIDTH  = 14,
    parameter int NUM_BATCHES    = 32,
    parameter int IDX_WIDTH      = 16
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           psad_valid_i,
    output logic                                           psad_ready_o,
    input  logic [EDGE_LEN*CAND_PER_BATCH*PSAD_BIT_WIDTH-1:0] psad_i,
    input  logic                                           flush_i,
`ifdef ME_EARLY_TERM_EN
    input  logic [SAD_BIT_WIDTH-1:0]                       term_thresh_i,
    output logic                                           best_early_o,
`endif
    output logic                                           best_valid_o,
    input  logic                                           best_ready_i,
    output logic [SAD_BIT_WIDTH-1:0]                       best_sad_o,
    output logic [IDX_WIDTH-1:0]                           best_idx_o
);

    localparam int LW   = $clog2(CAND_PER_BATCH);
    localparam int CW   = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam int SUMW = PSAD_BIT_WIDTH + $clog2(EDGE_LEN) + 1;
    localparam int AW   = ((SUMW > SAD_BIT_WIDTH) ? SUMW : SAD_BIT_WIDTH) + 1;

    localparam logic [CW-1:0]            LAST    = CW'(NUM_BATCHES - 1);
    localparam logic [SAD_BIT_WIDTH-1:0] SAD_MAX = '1;
    localparam logic [AW-1:0]            SAT     = AW'(SAD_MAX);

    // ---------------------------------------------------------------
    // Handshake and batch counter
    // ---------------------------------------------------------------
    logic          adv;
    logic          accept;
    logic [CW-1:0] batch_q, batch_d;
    logic          best_valid_q, best_valid_d;

    assign adv          = !best_valid_q || best_ready_i;
    assign psad_ready_o = adv && !flush_i;
    assign accept       = psad_valid_i && psad_ready_o;

    always_comb begin
        batch_d = batch_q;
        if (accept) begin
            batch_d = (batch_q == LAST) ? '0 : batch_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            batch_q <= '0;
        end else if (flush_i) begin
            batch_q <= '0;
        end else begin
            batch_q <= batch_d;
        end
    end

    // ---------------------------------------------------------------
    // S1: per-lane row sums with saturation
    // ---------------------------------------------------------------
    logic [AW-1:0]            lane_sum [CAND_PER_BATCH];
    logic [SAD_BIT_WIDTH-1:0] lane_d   [CAND_PER_BATCH];

    logic                     s1_valid_q;
    logic [CW-1:0]            s1_batch_q;
    logic [SAD_BIT_WIDTH-1:0] s1_sad_q [CAND_PER_BATCH];

    always_comb begin
        for (int i = 0; i < CAND_PER_BATCH; i++) begin
            lane_sum[i] = '0;
            for (int j = 0; j < EDGE_LEN; j++) begin
                lane_sum[i] = lane_sum[i] + AW'(
                    psad_i[(j*CAND_PER_BATCH+i)*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH]);
            end
            if (lane_sum[i] > SAT) begin
                lane_d[i] = SAD_MAX;
            end else begin
                lane_d[i] = lane_sum[i][SAD_BIT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_batch_q <= '0;
            s1_sad_q   <= '{default: '0};
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= accept;
            s1_batch_q <= batch_q;
            s1_sad_q   <= lane_d;
        end
    end

    // ---------------------------------------------------------------
    // S2: batch minimum, lowest lane wins ties
    // ---------------------------------------------------------------
    logic [SAD_BIT_WIDTH-1:0] bmin_d;
    logic [LW-1:0]            blane_d;

    logic                     s2_valid_q;
    logic [SAD_BIT_WIDTH-1:0] s2_min_q;
    logic [LW-1:0]            s2_lane_q;
    logic [CW-1:0]            s2_batch_q;
    logic                     s2_last_q;

    always_comb begin
        bmin_d  = s1_sad_q[0];
        blane_d = '0;
        for (int i = 1; i < CAND_PER_BATCH; i++) begin
            if (s1_sad_q[i] < bmin_d) begin
                bmin_d  = s1_sad_q[i];
                blane_d = LW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_min_q   <= '0;
            s2_lane_q  <= '0;
            s2_batch_q <= '0;
            s2_last_q  <= 1'b0;
        end else if (flush_i) begin
            s2_valid_q <= 1'b0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            s2_min_q   <= bmin_d;
            s2_lane_q  <= blane_d;
            s2_batch_q <= s1_batch_q;
            s2_last_q  <= (s1_batch_q == LAST);
        end
    end

    // ---------------------------------------------------------------
    // S3: running minimum and output register
    // ---------------------------------------------------------------
    logic [SAD_BIT_WIDTH-1:0] run_sad_q, run_sad_d;
    logic [IDX_WIDTH-1:0]     run_idx_q, run_idx_d;
    logic [SAD_BIT_WIDTH-1:0] cand_sad;
    logic [IDX_WIDTH-1:0]     cand_idx;
    logic [IDX_WIDTH-1:0]     entry_idx;
    logic                     take;
    logic                     early_hit;
    logic                     skip_hit;
    logic                     out_load;

    logic [SAD_BIT_WIDTH-1:0] best_sad_q, best_sad_d;
    logic [IDX_WIDTH-1:0]     best_idx_q, best_idx_d;

    assign entry_idx = (IDX_WIDTH'(s2_batch_q) << LW) | IDX_WIDTH'(s2_lane_q);
    assign take      = adv && s2_valid_q && !flush_i;

    // Batch 0 opens a block, so its entry loads unconditionally.
    always_comb begin
        if (s2_batch_q == '0 || s2_min_q < run_sad_q) begin
            cand_sad = s2_min_q;
            cand_idx = entry_idx;
        end else begin
            cand_sad = run_sad_q;
            cand_idx = run_idx_q;
        end
    end

`ifdef ME_EARLY_TERM_EN
    logic skip_q, skip_d;
    logic best_early_q, best_early_d;

    // After an early result the rest of the block is dropped until the
    // next batch 0 arrives, keeping block alignment intact.
    assign skip_hit  = skip_q && (s2_batch_q != '0);
    assign early_hit = !s2_last_q && (cand_sad <= term_thresh_i);

    always_comb begin
        skip_d       = skip_q;
        best_early_d = best_early_q;
        if (take && !skip_hit) begin
            skip_d = early_hit;
        end
        if (out_load) begin
            best_early_d = early_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            skip_q       <= 1'b0;
            best_early_q <= 1'b0;
        end else begin
            skip_q       <= flush_i ? 1'b0 : skip_d;
            best_early_q <= best_early_d;
        end
    end

    assign best_early_o = best_early_q;
`else
    assign skip_hit  = 1'b0;
    assign early_hit = 1'b0;
`endif

    assign out_load = take && !skip_hit && (s2_last_q || early_hit);

    always_comb begin
        run_sad_d = run_sad_q;
        run_idx_d = run_idx_q;
        if (take && !skip_hit) begin
            run_sad_d = cand_sad;
            run_idx_d = cand_idx;
        end
    end

    // A new result may load in the same cycle the old one is taken.
    always_comb begin
        best_valid_d = best_valid_q;
        best_sad_d   = best_sad_q;
        best_idx_d   = best_idx_q;
        if (best_valid_q && best_ready_i) begin
            best_valid_d = 1'b0;
        end
        if (out_load) begin
            best_valid_d = 1'b1;
            best_sad_d   = cand_sad;
            best_idx_d   = cand_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_sad_q <= '0;
            run_idx_q <= '0;
        end else if (flush_i) begin
            run_sad_q <= '0;
            run_idx_q <= '0;
        end else begin
            run_sad_q <= run_sad_d;
            run_idx_q <= run_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            best_valid_q <= 1'b0;
            best_sad_q   <= '0;
            best_idx_q   <= '0;
        end else begin
            best_valid_q <= best_valid_d;
            best_sad_q   <= best_sad_d;
            best_idx_q   <= best_idx_d;
        end
    end

    assign best_valid_o = best_valid_q;
    assign best_sad_o   = best_sad_q;
    assign best_idx_o   = best_idx_q;

endmodule
